// File: rtl/nixie_scan_if.sv
// Display-side bundle for the multiplexed nixie scanner: the BCD load
// interface toward the counter logic and the cathode/anode drive toward the pins.
interface nixie_scan_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] bcd;
   logic                load;
   logic                lzb;
   logic [9:0]          cathode;
   logic [DIGITS-1:0]   anode;
   logic                err;
   logic                busy_frame;

   modport master (
      output bcd, load, lzb,
      input  cathode, anode, err, busy_frame
   );

   modport slave (
      input  bcd, load, lzb,
      output cathode, anode, err, busy_frame
   );
endinterface

// File: rtl/nixie_scan_decoder.sv
// Multiplexed BCD-to-decimal nixie scanner: latches a packed BCD word and lights
// one digit at a time, with a blank gap between digits and frame-aligned updates.
module nixie_scan_decoder #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned DWELL  = 12000,
   parameter int unsigned BLANK  = 120
) (
   input  logic          clk,
   input  logic          rst,
   nixie_scan_if.slave   bus
);
   localparam int unsigned MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned BCD_W   = 4 * DIGITS;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [BCD_W-1:0]   disp;
   logic [BCD_W-1:0]   pend;
   logic               pend_vld;

   logic               blank_done_c;
   logic               on_done_c;
   logic               frame_end_c;
   logic               zero_run;
   logic [DIGITS-1:0]  lz_c;
   logic [DIGITS-1:0]  sel_c;
   logic [9:0]         cath_c;
   logic               err_c;

   // 4-to-10 decode; codes above 9 blank the cathodes like a CD4028
   function automatic logic [9:0] decode(input logic [3:0] nib);
      decode = (nib <= 4'd9) ? (10'd1 << nib) : 10'd0;
   endfunction

   // Phase terminal counts; frame ends on the last lit cycle of the top digit
   always_comb begin
      blank_done_c = (cnt == CNT_W'(BLANK - 1));
      on_done_c    = (cnt == CNT_W'(DWELL - 1));
      frame_end_c  = (state == ST_ON) && on_done_c && (idx == IDX_W'(DIGITS - 1));
   end

   // Leading-zero run from the top nibble down, plus the invalid-code flag
   always_comb begin
      zero_run = 1'b1;
      lz_c     = '0;
      err_c    = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (disp[4*k +: 4] == 4'd0);
         lz_c[k]  = zero_run & (k != 0);
         err_c    = err_c | (disp[4*k +: 4] > 4'd9);
      end
   end

   // Anode select and cathode pattern for the digit at the current index
   always_comb begin
      sel_c  = '0;
      cath_c = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            sel_c[k] = 1'b1;
            cath_c   = (bus.lzb && lz_c[k]) ? 10'd0 : decode(disp[4*k +: 4]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_BLANK;
         cnt            <= '0;
         idx            <= '0;
         disp           <= '0;
         pend           <= '0;
         pend_vld       <= 1'b0;
         bus.cathode    <= '0;
         bus.anode      <= '0;
         bus.err        <= 1'b0;
         bus.busy_frame <= 1'b0;
      end else begin
         bus.busy_frame <= frame_end_c;
         bus.err        <= err_c;

         // A load coinciding with the frame edge bypasses the pending stage
         if (frame_end_c) begin
            if (bus.load) begin
               disp <= bus.bcd;
            end else if (pend_vld) begin
               disp <= pend;
            end
            pend_vld <= 1'b0;
         end else if (bus.load) begin
            pend     <= bus.bcd;
            pend_vld <= 1'b1;
         end

         case (state)
            ST_BLANK: begin
               if (blank_done_c) begin
                  state       <= ST_ON;
                  cnt         <= '0;
                  bus.anode   <= sel_c;
                  bus.cathode <= cath_c;
               end else begin
                  cnt         <= cnt + CNT_W'(1);
                  bus.anode   <= '0;
                  bus.cathode <= '0;
               end
            end
            ST_ON: begin
               if (on_done_c) begin
                  state       <= ST_BLANK;
                  cnt         <= '0;
                  idx         <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                  bus.anode   <= '0;
                  bus.cathode <= '0;
               end else begin
                  cnt         <= cnt + CNT_W'(1);
                  bus.anode   <= sel_c;
                  bus.cathode <= cath_c;
               end
            end
            default: begin
               state <= ST_BLANK;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nixie_scan_decoder.sv
// Directed bench for nixie_scan_decoder (DIGITS=4, DWELL=8, BLANK=2): checks
// every cycle of each frame against hand-computed per-digit cathode patterns.
module tb_nixie_scan_decoder;
   localparam int unsigned DIGITS = 4;
   localparam int unsigned DWELL  = 8;
   localparam int unsigned BLANK  = 2;
   localparam int unsigned FRAME  = DIGITS * (DWELL + BLANK);

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   nixie_scan_if #(.DIGITS(DIGITS)) bus ();

   nixie_scan_decoder #(
      .DIGITS(DIGITS),
      .DWELL (DWELL),
      .BLANK (BLANK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs `stop` cycles of a frame from its start, optionally loading up to two
   // words at tick indices la1/la2 (1..FRAME); ec packs the expected cathode of
   // digit k at ec[10k +: 10] and e is the expected err level for the frame.
   task automatic run_frame(input string name, input logic [39:0] ec, input logic e,
                            input int stop, input int la1, input logic [15:0] v1,
                            input int la2, input logic [15:0] v2);
      int         p;
      int         d;
      logic       lit;
      logic [3:0] ea;
      logic [9:0] ecat;
      for (int i = 1; i <= stop; i++) begin
         if (i == la1) begin
            bus.bcd  = v1;
            bus.load = 1'b1;
         end else if (i == la2) begin
            bus.bcd  = v2;
            bus.load = 1'b1;
         end else begin
            bus.load = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         bus.load = 1'b0;
         p    = i % FRAME;
         d    = p / (DWELL + BLANK);
         lit  = (p % (DWELL + BLANK)) >= BLANK;
         ea   = lit ? (4'b0001 << d) : 4'b0000;
         ecat = lit ? ec[10*d +: 10] : 10'd0;
         check($sformatf("%s anode p%0d", name, p), 32'(bus.anode), 32'(ea));
         check($sformatf("%s cathode p%0d", name, p), 32'(bus.cathode), 32'(ecat));
         check($sformatf("%s busy p%0d", name, p), 32'(bus.busy_frame), 32'(p == 0));
         check($sformatf("%s err p%0d", name, p), 32'(bus.err), 32'(e));
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bus.bcd  = 16'h0000;
      bus.load = 1'b0;
      bus.lzb  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst anode", 32'(bus.anode), 32'h0);
      check("rst cathode", 32'(bus.cathode), 32'h0);
      check("rst err", 32'(bus.err), 32'h0);
      check("rst busy", 32'(bus.busy_frame), 32'h0);
      rst = 1'b0;

      // Free run of zeros, load lands mid-frame and must not tear it
      run_frame("f0_zero", {10'h001, 10'h001, 10'h001, 10'h001}, 1'b0, FRAME, 15, 16'h9305, 0, 16'h0);
      run_frame("f1_9305", {10'h200, 10'h008, 10'h001, 10'h020}, 1'b0, FRAME, 20, 16'h00A7, 0, 16'h0);
      run_frame("f2_00a7", {10'h001, 10'h001, 10'h000, 10'h080}, 1'b1, FRAME, 5, 16'h0040, 0, 16'h0);
      bus.lzb = 1'b1;
      run_frame("f3_lzb0040", {10'h000, 10'h000, 10'h010, 10'h001}, 1'b0, FRAME, 5, 16'h0000, 0, 16'h0);
      run_frame("f4_lzb0000", {10'h000, 10'h000, 10'h000, 10'h001}, 1'b0, FRAME, 3, 16'h1111, 30, 16'h2222);
      bus.lzb = 1'b0;
      // Second-to-last load is overwritten; boundary load goes straight to display
      run_frame("f5_2222", {10'h004, 10'h004, 10'h004, 10'h004}, 1'b0, FRAME, FRAME, 16'h7777, 0, 16'h0);
      run_frame("f6_7777", {10'h080, 10'h080, 10'h080, 10'h080}, 1'b0, 25, 10, 16'h5555, 0, 16'h0);

      // Asynchronous reset while digit 2 is lit, away from any clock edge
      check("pre_rst anode", 32'(bus.anode), 32'h4);
      #2 rst = 1'b1;
      #1;
      check("async_rst anode", 32'(bus.anode), 32'h0);
      check("async_rst cathode", 32'(bus.cathode), 32'h0);
      check("async_rst busy", 32'(bus.busy_frame), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("post_rst anode", 32'(bus.anode), 32'h0);
      run_frame("r0_zero", {10'h001, 10'h001, 10'h001, 10'h001}, 1'b0, FRAME, 0, 16'h0, 0, 16'h0);
      run_frame("r1_zero", {10'h001, 10'h001, 10'h001, 10'h001}, 1'b0, FRAME, 0, 16'h0, 0, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
